// File: rtl/ro_conditioner.sv
// rtl/ro_conditioner.sv - von Neumann debias, byte packing, byte FIFO and repetition health test for RO raw bits
module ro_conditioner #(
  parameter int FIFO_DEPTH = 4,
  parameter int REP_LIMIT  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          raw_bit,
  input  logic                          raw_valid,
  output logic [7:0]                    byte_out,
  output logic                          byte_valid,
  input  logic                          byte_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          health_fail,
  output logic                          overrun,
  input  logic                          clear_fail
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = $clog2(REP_LIMIT + 1);

  typedef enum logic {IDLE, HOLD} pair_state_t;

  pair_state_t   state, state_next;
  logic          held;
  logic [RW-1:0] rep_cnt, rep_next;
  logic          last_bit;
  logic [7:0]    pack;
  logic [2:0]    bit_cnt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  logic accept, trip, emit, push, pop, full, wr_en;
  logic [7:0] new_byte;

  assign accept = raw_valid & enable & ~health_fail & ~clear_fail;

  // rep_cnt == 0 means no previous raw bit since reset/clear
  always_comb begin
    rep_next = RW'(1);
    if (rep_cnt != '0 && raw_bit == last_bit) begin
      rep_next = (rep_cnt == RW'(REP_LIMIT)) ? rep_cnt : rep_cnt + RW'(1);
    end
  end

  assign trip     = accept & (rep_next == RW'(REP_LIMIT));
  assign emit     = accept & ~trip & (state == HOLD) & (raw_bit != held);
  assign new_byte = {pack[6:0], held};
  assign push     = emit & (bit_cnt == 3'd7);
  assign pop      = byte_valid & byte_ready;
  assign full     = (fifo_level == (AW + 1)'(FIFO_DEPTH));
  assign wr_en    = push & (~full | pop);

  always_comb begin
    state_next = state;
    if (clear_fail || !enable || trip) begin
      state_next = IDLE;
    end else if (accept) begin
      state_next = (state == IDLE) ? HOLD : IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= IDLE;
      held  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept && state == IDLE) held <= raw_bit;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rep_cnt     <= '0;
      last_bit    <= 1'b0;
      health_fail <= 1'b0;
    end else if (clear_fail) begin
      rep_cnt     <= '0;
      last_bit    <= 1'b0;
      health_fail <= 1'b0;
    end else if (accept) begin
      rep_cnt  <= rep_next;
      last_bit <= raw_bit;
      if (trip) health_fail <= 1'b1;
    end
  end

  // A tripped health test discards the partial byte along with the held bit
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pack    <= 8'h00;
      bit_cnt <= 3'd0;
    end else if (clear_fail || trip) begin
      pack    <= 8'h00;
      bit_cnt <= 3'd0;
    end else if (emit) begin
      pack    <= new_byte;
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= new_byte;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !pop)      fifo_level <= fifo_level + (AW + 1)'(1);
      else if (!wr_en && pop) fifo_level <= fifo_level - (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      overrun <= 1'b0;
    end else if (clear_fail) begin
      overrun <= 1'b0;
    end else if (push && full && !pop) begin
      overrun <= 1'b1;
    end
  end

  assign byte_out   = mem[rd_ptr];
  assign byte_valid = (fifo_level != '0);

endmodule

// File: doc/ro_conditioner.md
# ro_conditioner

Post-processing stage that consumes the raw XOR bit stream from the dual ring-oscillator sampler (one sampled bit per qualified clock) and turns it into conditioned entropy bytes. Applies von Neumann debiasing, packs debiased bits into bytes, buffers them in a small FIFO with a valid/ready output handshake, and runs a repetition-count health test on the raw stream. Sits between the RO sampling/shift stage and the byte consumer (output mux or host interface).

## Interface
Parameters:
- FIFO_DEPTH, 4, byte FIFO entries (power of two, >= 2)
- REP_LIMIT, 32, consecutive identical raw bits that trip the health test (>= 2)

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-high reset (reset asserted while 1)
- enable  in  1  1 = accept raw bits; 0 = ignore raw_valid
- raw_bit  in  1  raw sampled XOR bit
- raw_valid  in  1  raw_bit qualifier, sampled on clk
- byte_out  out  8  FIFO head byte
- byte_valid  out  1  FIFO non-empty
- byte_ready  in  1  consumer accepts byte_out this cycle
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held, 0..FIFO_DEPTH
- health_fail  out  1  sticky repetition-test failure
- overrun  out  1  sticky: completed byte dropped because FIFO full
- clear_fail  in  1  synchronous clear of health_fail, overrun and pipeline state

## Operation
- Accept event: raw_valid & enable & !health_fail & !clear_fail on a rising edge.
- Pair FSM, states IDLE / HOLD. IDLE + accept: store raw_bit, go HOLD. HOLD + accept: if raw_bit != held, emit held bit (10 -> 1, 01 -> 0), go IDLE; if equal, emit nothing, go IDLE. enable = 0 forces IDLE (held bit discarded); packer keeps partial byte.
- Packer: 8-bit shift reg, pack <= {pack[6:0], bit}, 3-bit count. On 8th emitted bit the byte {pack[6:0], bit} is pushed to FIFO and count wraps to 0. First emitted bit ends up in byte_out[7].
- FIFO: push on completed byte, pop on byte_valid & byte_ready. Full & push & pop same cycle: both happen, no drop, level unchanged. Full & push & no pop: byte dropped, overrun <= 1. Empty & pop cannot occur (byte_valid = 0). byte_out = head entry, in order.
- Health test: rep counter, width $clog2(REP_LIMIT+1), updated on raw_valid & enable & !health_fail. raw_bit == last raw bit: count+1, saturating at REP_LIMIT; else count = 1. First bit after reset/clear: count = 1. When the update reaches REP_LIMIT, health_fail <= 1 at that edge; same edge forces pair FSM IDLE and clears packer; that bit emits nothing.
- While health_fail = 1: raw bits ignored, no pushes; FIFO content stays drainable.
- clear_fail = 1: health_fail, overrun, rep count, last bit, pair FSM (IDLE), packer cleared next edge; raw bit that cycle ignored; FIFO untouched.

## Timing
- Reset values: byte_out 8'h00 (all FIFO storage 0), byte_valid 0, fifo_level 0, health_fail 0, overrun 0; FSM IDLE, packer and rep count 0.
- Byte latency: raw bit completing a byte sampled at edge E -> byte_valid = 1 and byte_out valid after E (one edge).
- Pop: byte_valid & byte_ready at edge E -> next entry (or byte_valid = 0) after E.
- fifo_level, health_fail, overrun registered, update at the causing edge.
- Reset mid-operation: all state and FIFO cleared immediately and asynchronously, independent of clk; partial byte lost.
- Max throughput: one byte per 16 accepted raw bits; FIFO sustains one pop per cycle.

## Test plan
- Raw pairs 10,01,10,10,01,01,10,01 (16 bits, byte_ready = 0) -> after 16th edge byte_valid = 1, byte_out = 8'hB2, fifo_level = 1.
- Raw pairs 00,11 repeated 20 times alternately -> no byte_valid, fifo_level = 0, health_fail = 0.
- 32 consecutive raw 1s (REP_LIMIT = 32) -> health_fail = 1 after 32nd edge; following 16 alternating pairs give no bytes; clear_fail pulse -> health_fail = 0, then 0xB2 pattern yields 8'hB2.
- byte_ready = 0, stream five bytes 8'h01..8'h05 -> fifo_level = 4, overrun = 1; draining yields 01,02,03,04 then byte_valid = 0.
- FIFO full, byte_ready = 1 on edge completing 5th byte -> no drop, overrun = 0, level stays 4, drain order 02,03,04,05.
- Assert rst_n after 5 debiased bits with one byte queued -> byte_valid 0, level 0, byte_out 0; next 0xB2 stream yields exactly 8'hB2.
